// File: rtl/line_fill_memory_pkg.sv
// rtl/line_fill_memory_pkg.sv - shared types, constants and width helpers for line_fill_memory
package line_fill_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    FILL = 2'd2
  } state_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Offset and line-index widths of the default geometry (8-byte lines, 2 KiB)
  localparam int OFS_W = $clog2(8);
  localparam int IDX_W = $clog2(2048 / 8);

  function automatic int ofs_width(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int idx_width(input int depth_bytes, input int line_bytes);
    return (depth_bytes / line_bytes > 1) ? $clog2(depth_bytes / line_bytes) : 1;
  endfunction

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/line_fill_memory_if.sv
// rtl/line_fill_memory_if.sv - requester/writer bundle for line_fill_memory
interface line_fill_memory_if #(
  parameter int NUM_REQ    = 2,
  parameter int LINE_BYTES = 8,
  parameter int ADDR_W     = 32
);
  logic [NUM_REQ-1:0]        miss;
  logic [NUM_REQ*ADDR_W-1:0] miss_addr;
  logic [NUM_REQ-1:0]        fill;
  logic [LINE_BYTES*8-1:0]   fill_data;
  logic                      fill_err;
  logic                      busy;
  logic                      we;
  logic [ADDR_W-1:0]         wr_addr;
  logic [LINE_BYTES*8-1:0]   wr_data;
  logic [LINE_BYTES-1:0]     wr_be;

  // Cache-side view: raises misses and writes, receives fills
  modport master (
    output miss, miss_addr, we, wr_addr, wr_data, wr_be,
    input  fill, fill_data, fill_err, busy
  );

  // Memory-side view
  modport slave (
    input  miss, miss_addr, we, wr_addr, wr_data, wr_be,
    output fill, fill_data, fill_err, busy
  );
endinterface

// File: rtl/line_fill_memory_rr_arbiter.sv
// rtl/line_fill_memory_rr_arbiter.sv - combinational fixed-priority / round-robin request picker
module rr_arbiter
  import line_fill_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int PTR_W   = sel_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               mode_i,   // 0 = fixed priority, 1 = round-robin
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               valid_o
);

  logic [PTR_W-1:0] start;
  logic [PTR_W-1:0] cand;

  // Scan requesters starting at index 0 (fixed) or the pointer (round-robin); first hit wins
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    start   = mode_i ? ptr_i : '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((int'(start) + k) % NUM_REQ);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
    if (valid_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/line_fill_memory.sv
// rtl/line_fill_memory.sv - line-fill backing memory with arbitrated single read path
module line_fill_memory
  import line_fill_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int LINE_BYTES  = 2 ** OFS_W,
  parameter int DEPTH_BYTES = (2 ** IDX_W) * (2 ** OFS_W),
  parameter int ADDR_W      = 32,
  parameter int LATENCY     = 2,
  parameter int ARB_MODE    = ARB_FIXED
) (
  input  logic clk,
  input  logic rst,
  line_fill_memory_if.slave bus
);

  localparam int OW     = ofs_width(LINE_BYTES);
  localparam int IW     = idx_width(DEPTH_BYTES, LINE_BYTES);
  localparam int PW     = sel_width(NUM_REQ);
  localparam int CW     = $clog2(LATENCY + 1);
  localparam int LW     = LINE_BYTES * 8;
  localparam int NLINES = DEPTH_BYTES / LINE_BYTES;
  localparam logic [ADDR_W-1:0] OFS_MASK  = ADDR_W'(LINE_BYTES - 1);
  localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(DEPTH_BYTES - LINE_BYTES);
  localparam logic              MODE_RR   = (ARB_MODE == ARB_RR);

  state_e             state_q, state_d;
  logic [PW-1:0]      win_q, win_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               err_q, err_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NUM_REQ-1:0] prev_fill_q;
  logic [LW-1:0]      fill_data_q, fill_data_d;
  logic [LW-1:0]      rd_q;
  logic [LW-1:0]      mem_q [NLINES];

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [NUM_REQ-1:0] fill_vec;
  logic [PW-1:0]      arb_idx;
  logic               arb_valid;
  logic [ADDR_W-1:0]  sel_addr;
  logic [ADDR_W-1:0]  sel_al;
  logic [ADDR_W-1:0]  wr_al;

  // A requester just served keeps its miss high for one cycle; mask it so it is not re-granted
  assign eligible = bus.miss & ~prev_fill_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i   (eligible),
    .mode_i  (MODE_RR),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Pick the granted requester's address slice
  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) sel_addr = bus.miss_addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign sel_al = sel_addr & ~OFS_MASK;
  assign wr_al  = bus.wr_addr & ~OFS_MASK;

  // Next-state logic: IDLE grants, READ counts the pipeline, FILL presents one cycle
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    fill_data_d = fill_data_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d = READ;
          win_d   = arb_idx;
          idx_d   = sel_al[OW +: IW];
          // Compare against the last valid line base so a near-top address cannot wrap into range
          err_d   = (sel_al > LAST_LINE);
          cnt_d   = '0;
          ptr_d   = (arb_idx == PW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
        end
      end
      READ: begin
        if (cnt_q == CW'(LATENCY)) begin
          state_d     = FILL;
          fill_data_d = err_q ? '0 : rd_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One-hot fill strobe for the latched winner
  always_comb begin
    fill_vec = '0;
    if (state_q == FILL) fill_vec[win_q] = 1'b1;
  end

  assign bus.fill      = fill_vec;
  assign bus.fill_data = fill_data_q;
  assign bus.fill_err  = (state_q == FILL) && err_q;
  assign bus.busy      = (state_q != IDLE);

  // Control registers; reset abandons any in-flight fill
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      win_q       <= '0;
      ptr_q       <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      prev_fill_q <= '0;
      fill_data_q <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      prev_fill_q <= fill_vec;
      fill_data_q <= fill_data_d;
    end
  end

  // Line array: read once on the first READ edge (old data on a same-edge write), byte-enabled writes
  always_ff @(posedge clk) begin
    if (state_q == READ && cnt_q == '0 && !err_q) rd_q <= mem_q[idx_q];
    if (bus.we && wr_al <= LAST_LINE) begin
      for (int k = 0; k < LINE_BYTES; k++) begin
        if (bus.wr_be[k]) mem_q[wr_al[OW +: IW]][k*8 +: 8] <= bus.wr_data[k*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_line_fill_memory.sv
// tb/tb_line_fill_memory.sv - self-checking bench for line_fill_memory
module tb_line_fill_memory;
  localparam int NR  = 2;
  localparam int LB  = 8;
  localparam int DB  = 2048;
  localparam int AW  = 32;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  line_fill_memory_if #(.NUM_REQ(NR), .LINE_BYTES(LB), .ADDR_W(AW)) if0 ();
  line_fill_memory_if #(.NUM_REQ(NR), .LINE_BYTES(LB), .ADDR_W(AW)) if1 ();

  line_fill_memory #(.NUM_REQ(NR), .LINE_BYTES(LB), .DEPTH_BYTES(DB), .ADDR_W(AW),
                     .LATENCY(LAT), .ARB_MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  line_fill_memory #(.NUM_REQ(NR), .LINE_BYTES(LB), .DEPTH_BYTES(DB), .ADDR_W(AW),
                     .LATENCY(LAT), .ARB_MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  logic [7:0]  mdl [DB];
  int          rr_ptr;
  int          errors = 0;
  int          checks = 0;
  logic [63:0] last_fd [2];
  logic [1:0]  first_fill;
  logic        last_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    logic [31:0] al;
    al = a & ~32'(LB - 1);
    return al <= 32'(DB - LB);
  endfunction

  function automatic logic [63:0] exp_line(input logic [31:0] a);
    logic [31:0] al;
    logic [63:0] r;
    al = a & ~32'(LB - 1);
    r  = '0;
    if (in_rng(a)) for (int k = 0; k < LB; k++) r[k*8 +: 8] = mdl[int'(al) + k];
    return r;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] be);
    logic [31:0] al;
    al = a & ~32'(LB - 1);
    if (in_rng(a)) for (int k = 0; k < LB; k++) if (be[k]) mdl[int'(al) + k] = d[k*8 +: 8];
  endtask

  task automatic drive_wr(input logic w, input logic [31:0] a, input logic [63:0] d, input logic [7:0] be);
    if0.we = w; if0.wr_addr = a; if0.wr_data = d; if0.wr_be = be;
    if1.we = w; if1.wr_addr = a; if1.wr_data = d; if1.wr_be = be;
  endtask

  task automatic wr_line(input logic [31:0] a, input logic [63:0] d, input logic [7:0] be);
    drive_wr(1'b1, a, d, be);
    @(posedge clk); @(negedge clk);
    drive_wr(1'b0, '0, '0, '0);
    model_write(a, d, be);
  endtask

  task automatic set_miss(input int sel, input logic [1:0] m, input logic [31:0] a0, input logic [31:0] a1);
    if (sel == 0) begin if0.miss = m; if0.miss_addr = {a1, a0}; end
    else          begin if1.miss = m; if1.miss_addr = {a1, a0}; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); @(negedge clk); end
    check("idle_busy0", 64'(if0.busy), 64'(0));
    check("idle_busy1", 64'(if1.busy), 64'(0));
    check("hold_data0", if0.fill_data, last_fd[0]);
    check("hold_data1", if1.fill_data, last_fd[1]);
  endtask

  task automatic run_misses(input int sel, input logic [1:0] mask, input logic [31:0] a0,
                            input logic [31:0] a1, input bit chk_lat);
    logic [1:0]  pend, live, f;
    logic [31:0] addr [2];
    logic [63:0] fd;
    logic        fe, b;
    int          order [$];
    int          base, pick, edges, got, ei;
    addr[0] = a0; addr[1] = a1;
    pend = mask;
    while (pend != 0) begin
      base = (sel == 1) ? rr_ptr : 0;
      pick = -1;
      for (int k = 0; k < NR; k++) begin
        int i;
        i = (base + k) % NR;
        if (pick < 0 && pend[i]) pick = i;
      end
      order.push_back(pick);
      pend[pick] = 1'b0;
      if (sel == 1) rr_ptr = (pick + 1) % NR;
    end
    live = mask;
    set_miss(sel, live, a0, a1);
    edges = 0; got = 0;
    while (got < order.size() && edges < 40) begin
      @(posedge clk); edges++; @(negedge clk);
      if (sel == 0) begin f = if0.fill; fd = if0.fill_data; fe = if0.fill_err; b = if0.busy; end
      else          begin f = if1.fill; fd = if1.fill_data; fe = if1.fill_err; b = if1.busy; end
      if (chk_lat && got == 0 && edges == 1) check("busy_after_grant", 64'(b), 64'(1));
      if (f != 0) begin
        ei = order[got];
        check("fill_onehot", 64'(f), 64'(1) << ei);
        check("fill_data", fd, exp_line(addr[ei]));
        check("fill_err", 64'(fe), 64'(!in_rng(addr[ei])));
        check("busy_in_fill", 64'(b), 64'(1));
        if (chk_lat && got == 0) check("fill_latency", 64'(edges), 64'(LAT + 2));
        if (got == 0) first_fill = f;
        last_fd[sel] = fd;
        last_err     = fe;
        live = live & ~f;
        set_miss(sel, live, a0, a1);
        got++;
      end else begin
        check("err_outside_fill", 64'(fe), 64'(0));
      end
    end
    check("fill_count", 64'(got), 64'(order.size()));
    set_miss(sel, 2'b00, '0, '0);
  endtask

  logic [63:0] old_line;
  logic [31:0] ra0, ra1, wa;
  logic [1:0]  rmask;
  int          rsel;
  bit          seen;

  initial begin
    rst = 1'b1;
    rr_ptr = 0;
    last_fd[0] = '0; last_fd[1] = '0;
    first_fill = '0; last_err = 1'b0;
    set_miss(0, 2'b00, '0, '0);
    set_miss(1, 2'b00, '0, '0);
    drive_wr(1'b0, '0, '0, '0);
    repeat (2) @(negedge clk);
    check("rst_fill0", 64'(if0.fill), 64'(0));
    check("rst_busy0", 64'(if0.busy), 64'(0));
    check("rst_err0", 64'(if0.fill_err), 64'(0));
    check("rst_data0", if0.fill_data, 64'(0));
    check("rst_busy1", 64'(if1.busy), 64'(0));
    check("rst_data1", if1.fill_data, 64'(0));
    rst = 1'b0;

    // Give every line a known value
    for (int l = 0; l < DB / LB; l++) wr_line(32'(l * LB), {$urandom, $urandom}, 8'hFF);

    // Basic fill and partial-byte write
    wr_line(32'h40, 64'h8877665544332211, 8'hFF);
    idle(2);
    run_misses(0, 2'b10, 32'h0, 32'h44, 1);
    check("tp_full_line", last_fd[0], 64'h8877665544332211);
    wr_line(32'h40, 64'hFFFFFFFF_AABBCCDD, 8'h0F);
    idle(2);
    run_misses(0, 2'b10, 32'h0, 32'h40, 1);
    check("tp_partial_be", last_fd[0], 64'h88776655_AABBCCDD);

    // Arbitration: fixed priority, then round-robin with pointer at 1
    idle(2);
    run_misses(0, 2'b11, 32'h100, 32'h208, 1);
    check("fixed_first", 64'(first_fill), 64'(2'b01));
    run_misses(1, 2'b01, 32'h10, 32'h0, 1);
    idle(2);
    run_misses(1, 2'b11, 32'h18, 32'h20, 1);
    check("rr_first", 64'(first_fill), 64'(2'b10));

    // Range boundary and dropped out-of-range writes
    idle(2);
    run_misses(0, 2'b01, 32'h7FC, 32'h0, 1);
    check("top_line_ok", 64'(last_err), 64'(0));
    idle(2);
    run_misses(0, 2'b01, 32'h800, 32'h0, 1);
    check("oob_err", 64'(last_err), 64'(1));
    check("oob_data", last_fd[0], 64'(0));
    idle(2);
    run_misses(0, 2'b01, 32'hFFFF_FFFC, 32'h0, 1);
    check("wrap_err", 64'(last_err), 64'(1));
    wr_line(32'h800, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF);
    wr_line(32'hFFFF_FFF8, 64'hCAFE_CAFE_CAFE_CAFE, 8'hFF);
    idle(2);
    run_misses(0, 2'b11, 32'h0, 32'h7F8, 1);

    // Read-before-write on the array-read edge; a later write is also not in this fill
    idle(2);
    old_line = exp_line(32'h300);
    set_miss(0, 2'b01, 32'h300, 32'h0);
    @(posedge clk); @(negedge clk);
    drive_wr(1'b1, 32'h300, 64'h1122334455667788, 8'hFF);
    @(posedge clk); @(negedge clk);
    drive_wr(1'b1, 32'h304, 64'hA5A55A5A_0F0FF0F0, 8'hFF);
    @(posedge clk); @(negedge clk);
    drive_wr(1'b0, '0, '0, '0);
    model_write(32'h300, 64'h1122334455667788, 8'hFF);
    model_write(32'h304, 64'hA5A55A5A_0F0FF0F0, 8'hFF);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk); @(negedge clk);
      if (if0.fill != 0) begin
        seen = 1'b1;
        check("coll_fill", 64'(if0.fill), 64'(2'b01));
        check("coll_old_data", if0.fill_data, old_line);
        last_fd[0] = if0.fill_data;
        set_miss(0, 2'b00, '0, '0);
      end
    end
    check("coll_seen", 64'(seen), 64'(1));
    set_miss(0, 2'b00, '0, '0);
    idle(2);
    run_misses(0, 2'b01, 32'h300, 32'h0, 1);
    check("coll_new_data", last_fd[0], 64'hA5A55A5A_0F0FF0F0);

    // Reset in the middle of a read
    idle(2);
    set_miss(0, 2'b01, 32'h80, 32'h0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("busy_in_read", 64'(if0.busy), 64'(1));
    rst = 1'b1;
    #1;
    check("arst_fill", 64'(if0.fill), 64'(0));
    check("arst_busy", 64'(if0.busy), 64'(0));
    check("arst_err", 64'(if0.fill_err), 64'(0));
    check("arst_data", if0.fill_data, 64'(0));
    set_miss(0, 2'b00, '0, '0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    rr_ptr = 0;
    last_fd[0] = '0; last_fd[1] = '0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); @(negedge clk);
      check("no_fill_after_rst", 64'(if0.fill), 64'(0));
    end
    run_misses(0, 2'b01, 32'h80, 32'h0, 1);
    idle(2);
    run_misses(1, 2'b11, 32'h88, 32'h90, 1);
    check("rr_ptr_reset", 64'(first_fill), 64'(2'b01));

    // Randomized writes and misses against the byte-array model
    for (int it = 0; it < 30; it++) begin
      wa = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 2200));
      wr_line(wa, {$urandom, $urandom}, 8'($urandom));
      idle(2);
      rsel  = int'($urandom_range(0, 1));
      rmask = 2'($urandom_range(1, 3));
      ra0   = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 2100));
      ra1   = 32'($urandom_range(0, 2100));
      run_misses(rsel, rmask, ra0, ra1, 1);
    end

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
